mem_device_responder: RTL and testbench

// Device-side responder for the core's req/gnt/rvalid memory protocol. It is the
// far end of the instr/data host ports. It serves them from an internal word array

---
 rtl/mem_device_pkg.sv | 14 +
 rtl/mem_resp_delay_line.sv | 37 +++
 rtl/mem_device_responder.sv | 116 +++++++++++
 tb/tb_mem_device_responder.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_device_pkg.sv
// Shared types and default timing for the req/gnt/rvalid memory device responder.
package mem_device_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    localparam int unsigned DefaultDepth          = 16384;
    localparam int unsigned DefaultGntDelay       = 0;
    localparam int unsigned DefaultRespLatency    = 1;
    localparam int unsigned DefaultMaxOutstanding = 2;

endpackage

// File: rtl/mem_resp_delay_line.sv
// Fixed-latency shift register of {valid, response}; the last stage drives the host outputs.
module mem_resp_delay_line
    import mem_device_pkg::*;
#(
    parameter int unsigned Latency = DefaultRespLatency
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [$bits(mem_resp_t)-1:0]  in_resp,
    output logic                          out_valid,
    output logic [$bits(mem_resp_t)-1:0]  out_resp
);

    logic      valid_sr [Latency];
    mem_resp_t resp_sr  [Latency];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(Latency); i++) begin
                valid_sr[i] <= 1'b0;
                resp_sr[i]  <= '0;
            end
        end else begin
            valid_sr[0] <= in_valid;
            resp_sr[0]  <= mem_resp_t'(in_resp);
            for (int i = 1; i < int'(Latency); i++) begin
                valid_sr[i] <= valid_sr[i-1];
                resp_sr[i]  <= resp_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[Latency-1];
    assign out_resp  = resp_sr[Latency-1];

endmodule

// File: rtl/mem_device_responder.sv
// Memory-side responder with programmable grant stall, fixed response latency and
// an outstanding-request credit limit; out-of-range indices answer with err.
module mem_device_responder
    import mem_device_pkg::*;
#(
    parameter int unsigned Depth          = DefaultDepth,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned GntDelay       = DefaultGntDelay,
    parameter int unsigned RespLatency    = DefaultRespLatency,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o
);

    localparam int unsigned MemIdxW = $clog2(Depth);
    localparam int unsigned StallW  = (GntDelay > 0) ? $clog2(GntDelay + 1) : 1;
    localparam int unsigned OutW    = $clog2(MaxOutstanding + 1);

    logic [AddrWidth-3:0] idx;
    logic [MemIdxW-1:0]   mem_idx;
    logic                 acc_err;
    logic                 unused_addr;

    logic [StallW-1:0]    stall_cnt, stall_cnt_nxt;
    logic [OutW-1:0]      outstanding, outstanding_nxt;

    logic [31:0]          mem [Depth];

    mem_resp_t                      resp_in;
    mem_resp_t                      resp_last;
    logic [$bits(mem_resp_t)-1:0]   resp_out;

    assign idx         = addr_i[AddrWidth-1:2];
    assign mem_idx     = idx[MemIdxW-1:0];
    assign acc_err     = {2'b00, idx} >= AddrWidth'(Depth);
    assign unused_addr = ^addr_i[1:0];

    // Reset masks the grant so nothing is written or queued in a reset cycle.
    assign gnt_o = !rst_i && req_i && (stall_cnt == StallW'(GntDelay))
                   && (outstanding < OutW'(MaxOutstanding));

    always_comb begin
        stall_cnt_nxt = stall_cnt;
        if (!req_i || gnt_o) begin
            stall_cnt_nxt = '0;
        end else if (stall_cnt != StallW'(GntDelay)) begin
            stall_cnt_nxt = stall_cnt + StallW'(1);
        end
    end

    always_comb begin
        outstanding_nxt = outstanding;
        case ({gnt_o, rvalid_o})
            2'b10:   outstanding_nxt = outstanding + OutW'(1);
            2'b01:   outstanding_nxt = outstanding - OutW'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt   <= '0;
            outstanding <= '0;
        end else begin
            stall_cnt   <= stall_cnt_nxt;
            outstanding <= outstanding_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_o && we_i && !acc_err) begin
            for (int j = 0; j < 4; j++) begin
                if (be_i[j]) begin
                    mem[mem_idx][8*j +: 8] <= wdata_i[8*j +: 8];
                end
            end
        end
    end

    // Read data is taken from the pre-write array state at the grant edge.
    always_comb begin
        resp_in = '0;
        if (gnt_o) begin
            resp_in.err = acc_err;
            if (!we_i && !acc_err) begin
                resp_in.rdata = mem[mem_idx];
            end
        end
    end

    mem_resp_delay_line #(
        .Latency (RespLatency)
    ) u_delay (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (gnt_o),
        .in_resp   (resp_in),
        .out_valid (rvalid_o),
        .out_resp  (resp_out)
    );

    assign resp_last = mem_resp_t'(resp_out);
    assign rdata_o   = resp_last.rdata;
    assign err_o     = resp_last.err;

endmodule

// File: tb/tb_mem_device_responder.sv
// Directed bench: three responder instances covering zero-wait, grant stall and
// long-latency credit-limited configurations.
module tb_mem_device_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b, req_c;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;

    logic        gnt_a, gnt_b, gnt_c;
    logic        rvalid_a, rvalid_b, rvalid_c;
    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        err_a, err_b, err_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_device_responder #(
        .Depth(256), .AddrWidth(32), .GntDelay(0), .RespLatency(1), .MaxOutstanding(1)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .err_o(err_a)
    );

    mem_device_responder #(
        .Depth(256), .AddrWidth(32), .GntDelay(3), .RespLatency(1), .MaxOutstanding(1)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .err_o(err_b)
    );

    mem_device_responder #(
        .Depth(256), .AddrWidth(32), .GntDelay(0), .RespLatency(4), .MaxOutstanding(2)
    ) u_c (
        .clk_i(clk), .rst_i(rst), .req_i(req_c), .gnt_o(gnt_c), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .err_o(err_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles spent waiting, or -1 if no grant within the budget.
    task automatic wait_gnt(input int which, output int waited);
        logic g;
        waited = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            g = (which == 0) ? gnt_a : (which == 1) ? gnt_b : gnt_c;
            if (g) begin
                waited = i;
                return;
            end
            tick();
        end
    endtask

    task automatic acc_a(input string tag, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic exp_err);
        int waited;
        we = w; addr = a; be = b; wdata = d; req_a = 1'b1;
        wait_gnt(0, waited);
        check({tag, "_gnt_same_cycle"}, 32'(waited), 32'd0);
        tick();
        req_a = 1'b0;
        #1;
        check({tag, "_rvalid"}, {31'd0, rvalid_a}, 32'd1);
        check({tag, "_rdata"}, rdata_a, exp_rd);
        check({tag, "_err"}, {31'd0, err_a}, {31'd0, exp_err});
        tick();
        check({tag, "_rvalid_pulse"}, {31'd0, rvalid_a}, 32'd0);
    endtask

    logic [31:0] dat [4];
    int          waited;

    initial begin
        dat[0] = 32'h0BAD_0001; dat[1] = 32'h0BAD_0002;
        dat[2] = 32'h0BAD_0003; dat[3] = 32'h0BAD_0004;

        // Reset with requests pending: grants must stay low.
        rst = 1'b1; req_a = 1'b1; req_b = 1'b1; req_c = 1'b1;
        we = 1'b0; addr = 32'h100; be = 4'h0; wdata = '0;
        tick(); tick();
        check("rst_gnt_a", {31'd0, gnt_a}, 32'd0);
        check("rst_gnt_c", {31'd0, gnt_c}, 32'd0);
        check("rst_rvalid_a", {31'd0, rvalid_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_err_a", {31'd0, err_a}, 32'd0);
        check("rst_rvalid_c", {31'd0, rvalid_c}, 32'd0);
        rst = 1'b0; req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        tick();

        // Full-word write then read.
        acc_a("t1_wr", 1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        acc_a("t1_rd", 1'b0, 32'h100, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte-enabled partial write.
        acc_a("t2_wr_full", 1'b1, 32'h104, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        acc_a("t2_wr_part", 1'b1, 32'h104, 4'b0010, 32'h0000_AB00, 32'h0, 1'b0);
        acc_a("t2_rd", 1'b0, 32'h104, 4'h0, 32'h0, 32'h1122_AB44, 1'b0);

        // Out-of-range and last-in-range accesses.
        acc_a("t5_wr0", 1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        acc_a("t5_rd_oor", 1'b0, 32'h400, 4'h0, 32'h0, 32'h0, 1'b1);
        acc_a("t5_wr_oor", 1'b1, 32'h400, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        acc_a("t5_rd0", 1'b0, 32'h0, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        acc_a("t5_wr_last", 1'b1, 32'h3FF, 4'hF, 32'h5A5A_A5A5, 32'h0, 1'b0);
        acc_a("t5_rd_last", 1'b0, 32'h3FC, 4'h0, 32'h0, 32'h5A5A_A5A5, 1'b0);

        // Grant stall of 3: grant on the 4th held-request cycle.
        we = 1'b0; addr = 32'h20; req_b = 1'b1;
        #1; check("t3_c0", {31'd0, gnt_b}, 32'd0); tick();
        check("t3_c1", {31'd0, gnt_b}, 32'd0); tick();
        check("t3_c2", {31'd0, gnt_b}, 32'd0); tick();
        check("t3_c3", {31'd0, gnt_b}, 32'd1); tick();
        req_b = 1'b0; #1;
        check("t3_rvalid", {31'd0, rvalid_b}, 32'd1);
        check("t3_err", {31'd0, err_b}, 32'd0);
        tick();
        // Drop after two cycles: counter restarts, no access.
        req_b = 1'b1;
        #1; check("t3d_c0", {31'd0, gnt_b}, 32'd0); tick();
        check("t3d_c1", {31'd0, gnt_b}, 32'd0); tick();
        req_b = 1'b0; #1;
        check("t3d_drop", {31'd0, gnt_b}, 32'd0); tick();
        check("t3d_no_rvalid", {31'd0, rvalid_b}, 32'd0);
        check("t3d_no_rdata", rdata_b, 32'd0);
        req_b = 1'b1;
        #1; check("t3r_c0", {31'd0, gnt_b}, 32'd0); tick();
        check("t3r_c1", {31'd0, gnt_b}, 32'd0); tick();
        check("t3r_c2", {31'd0, gnt_b}, 32'd0); tick();
        check("t3r_c3", {31'd0, gnt_b}, 32'd1); tick();
        req_b = 1'b0; #1;
        check("t3r_rvalid", {31'd0, rvalid_b}, 32'd1);
        tick();

        // Preload instance C.
        we = 1'b1; be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            addr = 32'h10 + 32'(4 * i); wdata = dat[i]; req_c = 1'b1;
            wait_gnt(2, waited);
            check("t4_preload_gnt", {31'd0, waited >= 0}, 32'd1);
            tick();
        end
        req_c = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Credit-limited back-to-back reads.
        we = 1'b0; addr = 32'h10; req_c = 1'b1;
        #1; check("t4_c0_gnt", {31'd0, gnt_c}, 32'd1); tick();
        addr = 32'h14;
        #1; check("t4_c1_gnt", {31'd0, gnt_c}, 32'd1); tick();
        addr = 32'h18;
        #1; check("t4_c2_gnt", {31'd0, gnt_c}, 32'd0);
        check("t4_c2_rvalid", {31'd0, rvalid_c}, 32'd0); tick();
        check("t4_c3_gnt", {31'd0, gnt_c}, 32'd0);
        check("t4_c3_rvalid", {31'd0, rvalid_c}, 32'd0); tick();
        check("t4_c4_rvalid", {31'd0, rvalid_c}, 32'd1);
        check("t4_c4_rdata", rdata_c, dat[0]);
        check("t4_c4_gnt", {31'd0, gnt_c}, 32'd0); tick();
        check("t4_c5_rvalid", {31'd0, rvalid_c}, 32'd1);
        check("t4_c5_rdata", rdata_c, dat[1]);
        check("t4_c5_gnt", {31'd0, gnt_c}, 32'd1); tick();
        addr = 32'h1C;
        #1; check("t4_c6_gnt", {31'd0, gnt_c}, 32'd1);
        check("t4_c6_rvalid", {31'd0, rvalid_c}, 32'd0); tick();
        req_c = 1'b0;
        check("t4_c7_rvalid", {31'd0, rvalid_c}, 32'd0); tick();
        check("t4_c8_rvalid", {31'd0, rvalid_c}, 32'd0); tick();
        check("t4_c9_rvalid", {31'd0, rvalid_c}, 32'd1);
        check("t4_c9_rdata", rdata_c, dat[2]); tick();
        check("t4_c10_rvalid", {31'd0, rvalid_c}, 32'd1);
        check("t4_c10_rdata", rdata_c, dat[3]); tick();
        check("t4_c11_rvalid", {31'd0, rvalid_c}, 32'd0);
        check("t4_c11_rdata", rdata_c, 32'd0);
        tick();

        // Reset with two responses in flight.
        addr = 32'h10; req_c = 1'b1;
        #1; check("t6_gnt0", {31'd0, gnt_c}, 32'd1); tick();
        addr = 32'h14;
        #1; check("t6_gnt1", {31'd0, gnt_c}, 32'd1); tick();
        req_c = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t6_no_rvalid", {31'd0, rvalid_c}, 32'd0);
            tick();
        end
        addr = 32'h18; req_c = 1'b1;
        #1; check("t6_post_gnt", {31'd0, gnt_c}, 32'd1); tick();
        addr = 32'h1C;
        #1; check("t6_post_gnt2", {31'd0, gnt_c}, 32'd1); tick();
        req_c = 1'b0;
        tick(); tick();
        check("t6_rvalid", {31'd0, rvalid_c}, 32'd1);
        check("t6_rdata", rdata_c, dat[2]);
        tick();
        check("t6_rvalid2", {31'd0, rvalid_c}, 32'd1);
        check("t6_rdata2", rdata_c, dat[3]);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
